// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared double-dabble converter: one requester's binary value
// is converted per W+2 cycles and returned as packed BCD tagged with its index.
module bcd_conv_arbiter #(
  parameter int NREQ   = 4,
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req,
  input  logic [NREQ*W-1:0]               bin_in,
  output logic [NREQ-1:0]                 gnt,
  output logic                            busy,
  output logic [4*DIGITS-1:0]             bcd_out,
  output logic [(NREQ>1?$clog2(NREQ):1)-1:0] bcd_id,
  output logic                            bcd_valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  if (10**DIGITS <= 2**W - 1) begin : g_digits_chk
    $error("DIGITS too small to hold 2**W-1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   id_q, id_d;
  logic [BW-1:0]   bcd_out_q, bcd_out_d;
  logic [IW-1:0]   bcd_id_q, bcd_id_d;
  logic            valid_q, valid_d;

  logic            found;
  logic [IW-1:0]   win;
  logic [BW-1:0]   adj;
  int              idx;

  // first requesting index at or after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] > 4'd4)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    bcd_out_d = bcd_out_q;
    bcd_id_d  = bcd_id_q;
    valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sh_d    = bin_in[win*W +: W];
          bcd_d   = '0;
          cnt_d   = '0;
          id_d    = win;
          rr_d    = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d   = DONE;
          bcd_out_d = {adj[BW-2:0], sh_q[W-1]};
          bcd_id_d  = id_q;
          valid_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      sh_q      <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      bcd_out_q <= '0;
      bcd_id_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      bcd_out_q <= bcd_out_d;
      bcd_id_q  <= bcd_id_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (rst_n && state_q == IDLE && found)
      gnt[win] = 1'b1;
  end

  assign busy      = (state_q != IDLE);
  assign bcd_out   = bcd_out_q;
  assign bcd_id    = bcd_id_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: model predicts grants and
// decimal results; a separate monitor checks each bcd_valid pulse.
module tb_bcd_conv_arbiter;

  localparam int NREQ   = 4;
  localparam int W      = 8;
  localparam int DIGITS = 3;
  localparam int IW     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*W-1:0]    bin_in;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [4*DIGITS-1:0]  bcd_out;
  logic [IW-1:0]        bcd_id;
  logic                 bcd_valid;

  bcd_conv_arbiter #(.NREQ(NREQ), .W(W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
    .gnt(gnt), .busy(busy), .bcd_out(bcd_out), .bcd_id(bcd_id),
    .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  due;
    int                  id;
    logic [4*DIGITS-1:0] bcd;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rr = 0;
  int   free_n = 0;
  bit   granted;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // one cycle: inputs already set just after negedge
  task automatic step();
    logic [NREQ-1:0] eg;
    int idx;
    #1;
    eg = '0;
    granted = 1'b0;
    chk("busy", busy, free_n > 0);
    if (rst_n && free_n == 0 && req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (!granted && req[idx]) begin
          granted = 1'b1;
          eg[idx] = 1'b1;
          q.push_back('{cyc + W + 1, idx, to_bcd(int'(bin_in[idx*W +: W]))});
          rr = (idx + 1) % NREQ;
          free_n = W + 1;
        end
      end
    end else if (free_n > 0) begin
      free_n--;
    end
    chk("gnt", gnt, eg);
    if (!rst_n) begin
      rr = 0;
      free_n = 0;
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic req_one(input int i, input int v);
    bin_in[i*W +: W] = W'(v);
    req[i] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (granted) break;
    end
    chk("grant_timeout", granted, 1);
    req[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_zero_outs();
    chk("rst_bcd_out", bcd_out, 0);
    chk("rst_bcd_id", bcd_id, 0);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("valid", bcd_valid, 1);
      chk("bcd_id", bcd_id, q[0].id);
      chk("bcd_out", bcd_out, q[0].bcd);
      void'(q.pop_front());
    end else begin
      chk("no_valid", bcd_valid, 0);
    end
  end

  initial begin
    int vals[6];
    vals = '{0, 9, 10, 99, 100, 128};
    rst_n  = 1'b0;
    req    = '0;
    bin_in = '0;
    @(negedge clk);
    idle(3);
    chk_zero_outs();
    chk("rst_gnt", gnt, 0);
    rst_n = 1'b1;
    idle(2);

    req_one(0, 255);
    idle(W + 2);
    foreach (vals[i]) req_one(1, vals[i]);
    idle(W + 2);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bin_in[0*W +: W] = 8'd37;
    bin_in[2*W +: W] = 8'd201;
    req = 4'b0101;
    idle(35);
    req = 4'b0000;
    idle(W + 2);

    bin_in = {8'd250, 8'd143, 8'd67, 8'd8};
    req = 4'b1111;
    idle(55);
    req = 4'b0000;
    idle(W + 2);

    req_one(2, 123);
    idle(4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero_outs();
    req_one(3, 199);
    idle(W + 2);

    for (int v = 0; v < 256; v++) req_one(v % NREQ, v);
    idle(W + 2);

    for (int n = 0; n < 400; n++) begin
      req = NREQ'($urandom_range(0, 15));
      bin_in = $urandom;
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    req = '0;
    idle(W + 4);
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
